// File: rtl/snake_pkg.sv
// Shared encodings for the snake game controller: direction codes, FSM state
// encodings and the direction helper functions.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_DOWN  = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_READY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite_dir(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

  // Buttons are {up,down,left,right}; the highest bit pressed wins.
  function automatic dir_t encode_dir_btn(input logic [3:0] btn);
    if (btn[3]) return DIR_UP;
    if (btn[2]) return DIR_DOWN;
    if (btn[1]) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/snake_game_controller_if.sv
// Command/response bundle between the game controller and the snake/food manager.
interface snake_game_controller_if;
  import snake_pkg::*;

  // All signals are single-cycle strobes or levels with no valid/ready pairing:
  // a strobe is consumed on the clock edge it is high and there is no backpressure.
  logic reset_cmd_out;
  logic snake_move_cmd_out;
  dir_t current_direction_out;
  logic generate_food_cmd_out;
  logic collision_in;
  logic food_eaten_in;

  modport master (
    output reset_cmd_out, snake_move_cmd_out, current_direction_out, generate_food_cmd_out,
    input  collision_in, food_eaten_in
  );

  modport slave (
    input  reset_cmd_out, snake_move_cmd_out, current_direction_out, generate_food_cmd_out,
    output collision_in, food_eaten_in
  );

endinterface

// File: rtl/snake_move_timer.sv
// Move-pulse timer: period register, counter and terminal tick.
// SNAKE_SPEEDUP_EN shortens the period on every counted food, floored at MIN_PERIOD.
module snake_move_timer #(
  parameter int unsigned MOVE_PERIOD = 5_000_000,
  parameter int unsigned MIN_PERIOD  = 1_000_000,
  parameter int unsigned SPEED_STEP  = 250_000,
  parameter int unsigned PERIOD_W    = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic reload,
  input  logic food_tick,
  output logic tick
);

  localparam logic [PERIOD_W-1:0] START_PERIOD = PERIOD_W'(MOVE_PERIOD);

  if (MOVE_PERIOD < 4 || MIN_PERIOD < 4 ||
      (64'(MIN_PERIOD) + 64'(SPEED_STEP)) >= (64'd1 << PERIOD_W)) begin : g_bad_cfg
    $error("snake_move_timer: illegal period configuration");
  end

  // period_q is the target; active_q is what the counter compares against and
  // only picks up period_q at a wrap, so a mid-count change never skips a tick.
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] active_q, active_d;
  logic [PERIOD_W-1:0] count_q, count_d;

  assign tick = enable && (count_q == active_q - PERIOD_W'(1));

`ifdef SNAKE_SPEEDUP_EN
  localparam logic [PERIOD_W-1:0] FLOOR_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_P  = PERIOD_W'(SPEED_STEP);
  localparam logic [PERIOD_W-1:0] KNEE_P  = PERIOD_W'(MIN_PERIOD + SPEED_STEP);
`else
  logic unused_food_tick;
  assign unused_food_tick = food_tick;
`endif

  always_comb begin
    period_d = period_q;
    active_d = active_q;
    count_d  = count_q;
    if (reload) begin
      period_d = START_PERIOD;
      active_d = START_PERIOD;
      count_d  = '0;
    end else begin
`ifdef SNAKE_SPEEDUP_EN
      if (food_tick) period_d = (period_q >= KNEE_P) ? period_q - STEP_P : FLOOR_P;
`endif
      if (tick) begin
        count_d  = '0;
        active_d = period_d;
      end else if (enable) begin
        count_d = count_q + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= START_PERIOD;
      active_q <= START_PERIOD;
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/snake_game_controller.sv
// Game sequencer for the snake/food manager: FSM, direction filter, score and
// move timing. Optional SNAKE_SPEEDUP_EN speeds up moves as food is eaten.
module snake_game_controller
  import snake_pkg::*;
#(
  parameter int unsigned MOVE_PERIOD = 5_000_000,
  parameter int unsigned MIN_PERIOD  = 1_000_000,
  parameter int unsigned SPEED_STEP  = 250_000,
  parameter int unsigned PERIOD_W    = 23,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset_in,
  input  logic                     start_btn_in,
  input  logic                     pause_btn_in,
  input  logic [3:0]               dir_btn_in,
  snake_game_controller_if.master  mgr,
  output logic [SCORE_W-1:0]       score_out,
  output logic [2:0]               game_state_out,
  output logic                     game_over_out
);

  game_state_e        state_q, state_d;
  logic               reset_cmd_q, reset_cmd_d;
  logic               move_q, move_d;
  logic               food_q, food_d;
  logic               game_over_q, game_over_d;
  dir_t               dir_q, dir_d;
  dir_t               pending_q, pending_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic run_live;
  logic food_tick;
  logic tick;
  dir_t btn_dir;

  // A collision freezes everything else in the cycle it arrives.
  assign run_live = (state_q == ST_RUN) && !mgr.collision_in;
  assign btn_dir  = encode_dir_btn(dir_btn_in);

  snake_move_timer #(
    .MOVE_PERIOD (MOVE_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .SPEED_STEP  (SPEED_STEP),
    .PERIOD_W    (PERIOD_W)
  ) u_timer (
    .clk       (clk),
    .rst       (reset_in),
    .enable    (run_live),
    .reload    (state_q == ST_INIT),
    .food_tick (food_tick),
    .tick      (tick)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    score_d   = score_q;
    move_d    = 1'b0;
    food_d    = 1'b0;
    food_tick = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        state_d   = ST_READY;
        dir_d     = DIR_RIGHT;
        pending_d = DIR_RIGHT;
        score_d   = '0;
      end
      ST_READY: if (start_btn_in) state_d = ST_RUN;
      ST_RUN: begin
        if (mgr.collision_in)     state_d = ST_OVER;
        else if (pause_btn_in)    state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_btn_in) state_d = ST_RUN;
      ST_OVER:  if (start_btn_in) state_d = ST_INIT;
      default:  state_d = ST_INIT;
    endcase

    if (run_live) begin
      if (tick) begin
        move_d = 1'b1;
        dir_d  = pending_q;
      end
      // Reversal is judged against the committed heading, not the pending one.
      if (|dir_btn_in && (btn_dir != opposite_dir(dir_q))) pending_d = btn_dir;
      if (mgr.food_eaten_in) begin
        food_d    = 1'b1;
        food_tick = 1'b1;
        if (score_q != '1) score_d = score_q + SCORE_W'(1);
      end
    end
  end

  assign reset_cmd_d = (state_d == ST_INIT);
  assign game_over_d = (state_d == ST_OVER);

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_INIT;
      reset_cmd_q <= 1'b1;
      move_q      <= 1'b0;
      food_q      <= 1'b0;
      game_over_q <= 1'b0;
      dir_q       <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      reset_cmd_q <= reset_cmd_d;
      move_q      <= move_d;
      food_q      <= food_d;
      game_over_q <= game_over_d;
      dir_q       <= dir_d;
      pending_q   <= pending_d;
      score_q     <= score_d;
    end
  end

  assign mgr.reset_cmd_out         = reset_cmd_q;
  assign mgr.snake_move_cmd_out    = move_q;
  assign mgr.current_direction_out = dir_q;
  assign mgr.generate_food_cmd_out = food_q;
  assign score_out                 = score_q;
  assign game_state_out            = state_q;
  assign game_over_out             = game_over_q;

endmodule

// File: tb/tb_snake_game_controller.sv
// Self-checking bench for snake_game_controller; adapts expected periods when
// SNAKE_SPEEDUP_EN is defined.
`timescale 1ns/1ps
module tb_snake_game_controller;
  import snake_pkg::*;

`ifdef SNAKE_SPEEDUP_EN
  localparam int unsigned MP = 10, MINP = 5, STEP = 3;
`else
  localparam int unsigned MP = 4, MINP = 4, STEP = 1;
`endif
  localparam int SW = 8;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          start_btn_in = 1'b0;
  logic          pause_btn_in = 1'b0;
  logic [3:0]    dir_btn_in = 4'b0;
  logic [SW-1:0] score_out;
  logic [2:0]    game_state_out;
  logic          game_over_out;

  snake_game_controller_if mgr_if();

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int last = 0;
  logic [31:0] exp_q[$];

  snake_game_controller #(
    .MOVE_PERIOD (MP),
    .MIN_PERIOD  (MINP),
    .SPEED_STEP  (STEP),
    .PERIOD_W    (23),
    .SCORE_W     (SW)
  ) dut (
    .clk            (clk),
    .reset_in       (reset_in),
    .start_btn_in   (start_btn_in),
    .pause_btn_in   (pause_btn_in),
    .dir_btn_in     (dir_btn_in),
    .mgr            (mgr_if.master),
    .score_out      (score_out),
    .game_state_out (game_state_out),
    .game_over_out  (game_over_out)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse_start();
    start_btn_in = 1'b1; @(negedge clk); start_btn_in = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_btn_in = 1'b1; @(negedge clk); pause_btn_in = 1'b0;
  endtask

  task automatic press_dir(input logic [3:0] b);
    dir_btn_in = b; @(negedge clk); dir_btn_in = 4'b0;
  endtask

  task automatic pulse_food();
    mgr_if.food_eaten_in = 1'b1; @(negedge clk); mgr_if.food_eaten_in = 1'b0;
  endtask

  task automatic wait_move(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (mgr_if.snake_move_cmd_out === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (game_state_out !== 3'd0) $display("FAIL rst_state got %0d want 0", game_state_out); else n_pass++;
    n_total++; if (mgr_if.reset_cmd_out !== 1'b1) $display("FAIL rst_cmd got %b want 1", mgr_if.reset_cmd_out); else n_pass++;
    n_total++; if (mgr_if.current_direction_out !== 2'b11) $display("FAIL rst_dir got %b want 11", mgr_if.current_direction_out); else n_pass++;
    n_total++; if (mgr_if.snake_move_cmd_out !== 1'b0 || mgr_if.generate_food_cmd_out !== 1'b0 || game_over_out !== 1'b0)
      $display("FAIL rst_pulses got move=%b food=%b over=%b want 0", mgr_if.snake_move_cmd_out, mgr_if.generate_food_cmd_out, game_over_out); else n_pass++;
    reset_in = 1'b0;
    n_total++; if (mgr_if.reset_cmd_out !== 1'b1) $display("FAIL init_cmd got %b want 1", mgr_if.reset_cmd_out); else n_pass++;
    @(negedge clk);
    n_total++; if (game_state_out !== 3'd1) $display("FAIL ready_state got %0d want 1", game_state_out); else n_pass++;
    n_total++; if (mgr_if.reset_cmd_out !== 1'b0) $display("FAIL ready_cmd got %b want 0", mgr_if.reset_cmd_out); else n_pass++;
    n_total++; if (score_out !== 8'd0 || mgr_if.current_direction_out !== 2'b11)
      $display("FAIL ready_vals got score=%0d dir=%b want 0/11", score_out, mgr_if.current_direction_out); else n_pass++;
  endtask

  task automatic test_move_period();
    bit ok;
    logic [31:0] exp;
    repeat (2) @(negedge clk);
    n_total++; if (mgr_if.snake_move_cmd_out !== 1'b0) $display("FAIL ready_no_move got %b want 0", mgr_if.snake_move_cmd_out); else n_pass++;
    pulse_start();
    n_total++; if (game_state_out !== 3'd2) $display("FAIL run_state got %0d want 2", game_state_out); else n_pass++;
    last = cyc;
    repeat (3) exp_q.push_back(MP);
    for (int k = 0; k < 3; k++) begin
      wait_move(ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL move_timeout pulse %0d got none want interval %0d", k, exp);
      else if (32'(cyc - last) !== exp) $display("FAIL move_interval pulse %0d got %0d want %0d", k, cyc - last, exp);
      else n_pass++;
      last = cyc;
    end
    @(negedge clk);
    n_total++; if (mgr_if.snake_move_cmd_out !== 1'b0) $display("FAIL move_width got %b want 0", mgr_if.snake_move_cmd_out); else n_pass++;
  endtask

  task automatic test_direction();
    bit ok;
    logic [31:0] exp;
    logic [3:0] btn_a [3] = '{4'b0010, 4'b1000, 4'b0011};
    logic [3:0] btn_b [3] = '{4'b0000, 4'b0010, 4'b0000};
    logic [1:0] want  [3] = '{2'b11, 2'b00, 2'b10};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'(want[k]));
      press_dir(btn_a[k]);
      if (btn_b[k] != 4'b0) press_dir(btn_b[k]);
      wait_move(ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL dir_timeout case %0d got none want %b", k, exp[1:0]);
      else if (mgr_if.current_direction_out !== exp[1:0])
        $display("FAIL dir case %0d got %b want %b", k, mgr_if.current_direction_out, exp[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_food();
    logic [31:0] exp;
    n_total++; if (score_out !== 8'd0) $display("FAIL food_pre_score got %0d want 0", score_out); else n_pass++;
    exp_q.push_back(32'd1);
    pulse_food();
    exp = exp_q.pop_front();
    n_total++; if (mgr_if.generate_food_cmd_out !== 1'b1) $display("FAIL food_cmd got %b want 1", mgr_if.generate_food_cmd_out); else n_pass++;
    n_total++; if (32'(score_out) !== exp) $display("FAIL food_score got %0d want %0d", score_out, exp); else n_pass++;
    @(negedge clk);
    n_total++; if (mgr_if.generate_food_cmd_out !== 1'b0) $display("FAIL food_width got %b want 0", mgr_if.generate_food_cmd_out); else n_pass++;
    mgr_if.food_eaten_in = 1'b1;
    repeat (300) @(negedge clk);
    mgr_if.food_eaten_in = 1'b0;
    n_total++; if (score_out !== 8'd255) $display("FAIL score_sat got %0d want 255", score_out); else n_pass++;
    pulse_food();
    n_total++; if (score_out !== 8'd255 || mgr_if.generate_food_cmd_out !== 1'b1)
      $display("FAIL score_hold got score=%0d cmd=%b want 255/1", score_out, mgr_if.generate_food_cmd_out); else n_pass++;
  endtask

  task automatic test_collision();
    bit ok;
    int moves;
    wait_move(ok);
    n_total++; if (!ok) $display("FAIL coll_wait got no move want move"); else n_pass++;
    mgr_if.collision_in = 1'b1;
    mgr_if.food_eaten_in = 1'b1;
    @(negedge clk);
    mgr_if.collision_in = 1'b0;
    mgr_if.food_eaten_in = 1'b0;
    n_total++; if (game_state_out !== 3'd4 || game_over_out !== 1'b1)
      $display("FAIL over_state got %0d/%b want 4/1", game_state_out, game_over_out); else n_pass++;
    n_total++; if (mgr_if.generate_food_cmd_out !== 1'b0) $display("FAIL over_food got %b want 0", mgr_if.generate_food_cmd_out); else n_pass++;
    n_total++; if (score_out !== 8'd255) $display("FAIL over_score got %0d want 255", score_out); else n_pass++;
    moves = 0;
    repeat (3 * MP + 5) begin
      @(negedge clk);
      if (mgr_if.snake_move_cmd_out === 1'b1 || mgr_if.generate_food_cmd_out === 1'b1) moves++;
    end
    n_total++; if (moves !== 0) $display("FAIL over_quiet got %0d pulses want 0", moves); else n_pass++;
    pulse_start();
    n_total++; if (game_state_out !== 3'd0 || mgr_if.reset_cmd_out !== 1'b1)
      $display("FAIL restart_init got %0d/%b want 0/1", game_state_out, mgr_if.reset_cmd_out); else n_pass++;
    @(negedge clk);
    n_total++; if (game_state_out !== 3'd1 || score_out !== 8'd0 || mgr_if.current_direction_out !== 2'b11)
      $display("FAIL restart_ready got st=%0d score=%0d dir=%b want 1/0/11", game_state_out, score_out, mgr_if.current_direction_out); else n_pass++;
  endtask

  task automatic test_speedup_pause();
    bit ok;
    int p, c_a, c_b, moves;
    logic [31:0] exp;
    p = MP;
    exp_q.push_back(MP);
    exp_q.push_back(MP);
    for (int k = 0; k < 3; k++) begin
`ifdef SNAKE_SPEEDUP_EN
      p = (p >= int'(MINP + STEP)) ? p - int'(STEP) : int'(MINP);
`endif
      exp_q.push_back(32'(p));
    end
    pulse_start();
    last = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_move(ok);
      exp = exp_q.pop_front();
      n_total++;
      if (!ok) $display("FAIL speed_timeout pulse %0d got none want %0d", k, exp);
      else if (32'(cyc - last) !== exp) $display("FAIL speed_interval pulse %0d got %0d want %0d", k, cyc - last, exp);
      else n_pass++;
      last = cyc;
      if (k < 3) pulse_food();
    end
    n_total++; if (score_out !== 8'd3) $display("FAIL speed_score got %0d want 3", score_out); else n_pass++;
    @(negedge clk);
    c_a = cyc;
    pulse_pause();
    n_total++; if (game_state_out !== 3'd3) $display("FAIL pause_state got %0d want 3", game_state_out); else n_pass++;
    press_dir(4'b1000);
    moves = 0;
    repeat (12) begin
      @(negedge clk);
      if (mgr_if.snake_move_cmd_out === 1'b1) moves++;
    end
    n_total++; if (moves !== 0) $display("FAIL pause_quiet got %0d moves want 0", moves); else n_pass++;
    c_b = cyc;
    pulse_pause();
    n_total++; if (game_state_out !== 3'd2) $display("FAIL unpause_state got %0d want 2", game_state_out); else n_pass++;
    exp_q.push_back(32'(p + (c_b - c_a)));
    exp_q.push_back(32'(DIR_RIGHT));
    wait_move(ok);
    exp = exp_q.pop_front();
    n_total++;
    if (!ok) $display("FAIL pause_timeout got none want %0d", exp);
    else if (32'(cyc - last) !== exp) $display("FAIL pause_interval got %0d want %0d", cyc - last, exp);
    else n_pass++;
    exp = exp_q.pop_front();
    n_total++; if (mgr_if.current_direction_out !== exp[1:0])
      $display("FAIL pause_dir got %b want %b", mgr_if.current_direction_out, exp[1:0]); else n_pass++;
  endtask

  task automatic test_reset_midgame();
    @(negedge clk);
    reset_in = 1'b1;
    #2;
    n_total++; if (game_state_out !== 3'd0 || mgr_if.reset_cmd_out !== 1'b1 || score_out !== 8'd0)
      $display("FAIL midrst got st=%0d cmd=%b score=%0d want 0/1/0", game_state_out, mgr_if.reset_cmd_out, score_out); else n_pass++;
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    n_total++; if (game_state_out !== 3'd1) $display("FAIL midrst_ready got %0d want 1", game_state_out); else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    mgr_if.collision_in  = 1'b0;
    mgr_if.food_eaten_in = 1'b0;
    test_reset();
    test_move_period();
    test_direction();
    test_food();
    test_collision();
    test_speedup_pause();
    test_reset_midgame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
